uart_nic: RTL
=============

Name: uart_nic

Overview:
UART network-interface block that sits between the OS-simulator stage and the serial line. It accepts bytes from the OS side on a write strobe and queues them in a TX FIFO. It serializes those bytes as 8N1 frames on `tx`. In the other direction it deserializes frames from `rx` into an RX FIFO and presents them to the OS side with a data-available flag and a read strobe.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 115200, line bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD, integer division, must be ≥ 4
FIFO_DEPTH, 8, entries per FIFO; power of 2, ≥ 2

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
write_nic  input  1  push `send_data_to_nic` into the TX FIFO this cycle
send_data_to_nic  input  8  byte to transmit
read_nic  input  1  pop the RX FIFO head this cycle
rec_data_from_nic  output  8  RX FIFO head (first-word fall-through)
send_data_o  output  1  RX FIFO non-empty
tx_full  output  1  TX FIFO full
rx  input  1  serial line in, idle high, asynchronous
tx  output  1  serial line out, idle high
rx_overrun  output  1  sticky: a received byte was dropped because the RX FIFO was full
frame_err  output  1  sticky: a stop bit was sampled low

Behaviour:
- Reset is asynchronous on `rst_n` low. All state clears:
  - FIFOs empty, pointers 0
  - `tx`=1, `send_data_o`=0, `tx_full`=0, `rx_overrun`=0, `frame_err`=0, `rec_data_from_nic`=0
  - Both engines go to IDLE.
  - Reset mid-frame aborts the frame, with no partial byte stored.
- TX FIFO:
  - `write_nic` while not full pushes on the clock edge.
  - `write_nic` while full drops the byte; no state changes.
  - Pointers are log2(FIFO_DEPTH)+1 bits wide, and full/empty are derived from them.
  - Wrap-around is natural modulo.
- TX engine states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, pop the head into the shift register on the same edge, then go to START.
  - START: drive `tx`=0 for CLKS_PER_BIT cycles.
  - DATA: drive 8 bits LSB-first, each for CLKS_PER_BIT cycles.
  - STOP: drive `tx`=1 for CLKS_PER_BIT cycles, then return to IDLE.
  - Back-to-back frames need no extra idle cycles between stop and the next start, apart from the single IDLE cycle.
  - `tx` is registered.
- RX input: `rx` passes through a 2-FF synchronizer before use.
- RX engine states: IDLE, START, DATA, STOP.
  - IDLE: on a synchronized falling edge, go to START.
  - START: wait CLKS_PER_BIT/2 cycles, then sample. If the sample is high it was a glitch: return to IDLE. Otherwise go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles (mid-bit), shifting 8 bits LSB-first.
  - STOP: sample after CLKS_PER_BIT cycles.
    - Sample high: push the byte if the RX FIFO is not full; if full, set `rx_overrun` and drop the byte.
    - Sample low: set `frame_err` and discard the byte.
    - In both cases return to IDLE.
- RX FIFO read side:
  - `read_nic` while non-empty pops on the edge.
  - `rec_data_from_nic` updates to the next head, or holds the last value once empty.
  - `read_nic` while empty is ignored.
  - `send_data_o` = not empty, registered with the pointers.
- Simultaneous RX push and `read_nic` pop on a full FIFO: the pop is processed first, so the push succeeds with no overrun. The same ordering applies to TX write and engine pop.
- Sticky flags clear only on reset.

Optional Feature:
- Macro: UART_NIC_PARITY_EN.
- Defined:
  - TX inserts an even-parity bit (XOR of the 8 data bits) after DATA.
  - RX samples and checks that bit.
  - On a mismatch, the byte is discarded and `frame_err` is set.
  - Frame length is 11 bits.
- Undefined: 8N1 frames of 10 bits, no parity state, no parity logic.

Test Plan:
All scenarios use CLK_FREQ=16, BAUD=1, giving CLKS_PER_BIT=16.
- Reset then idle 50 cycles -> `tx`=1, `send_data_o`=0, `tx_full`=0, both flags 0.
- `write_nic` with 0xA5 -> `tx` shows start 0, then bits 1,0,1,0,0,1,0,1, then stop 1, each held exactly 16 cycles; the frame starts 2 cycles after the write.
- Loop `tx` to `rx`, write 0x3C and 0xF0 back-to-back -> `send_data_o` rises; `rec_data_from_nic`=0x3C; `read_nic` pulse -> 0xF0; second pulse -> `send_data_o`=0.
- Write 10 bytes in 10 consecutive cycles with FIFO_DEPTH=8 -> `tx_full` asserts. With the engine having popped 1, bytes 1–9 are transmitted in order and the 10th is dropped.
- Drive 9 valid frames 0x01..0x09 on `rx` with no reads -> FIFO holds 0x01..0x08, `rx_overrun`=1, and 0x09 is lost.
- Drive a frame 0x55 with the stop bit low -> `frame_err`=1 and `send_data_o` stays 0. A 4-cycle low glitch on `rx` produces no byte and no error.

Source files
------------

// File: rtl/uart_nic.sv
// rtl/uart_nic.sv - UART NIC: TX/RX byte FIFOs around 8N1 serializer/deserializer.
// Optional even-parity framing is enabled with `define UART_NIC_PARITY_EN.
module uart_nic #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       write_nic,
  input  logic [7:0] send_data_to_nic,
  input  logic       read_nic,
  output logic [7:0] rec_data_from_nic,
  output logic       send_data_o,
  output logic       tx_full,
  input  logic       rx,
  output logic       tx,
  output logic       rx_overrun,
  output logic       frame_err
);

  localparam int CPB  = CLK_FREQ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = $clog2(CPB);
  localparam logic [CW-1:0] BIT_END  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_NIC_PARITY_EN
    S_PAR,
`endif
    S_STOP
  } state_e;

  // ---------------- TX FIFO ----------------
  logic [7:0]  tx_mem_q [FIFO_DEPTH];
  logic [AW:0] tx_wp_q, tx_rp_q, tx_wp_d, tx_rp_d;
  logic        tx_empty, tx_pop, tx_push;
  logic [7:0]  tx_head;
  state_e      tx_st_q;

  assign tx_empty = (tx_wp_q == tx_rp_q);
  assign tx_full  = (tx_wp_q[AW] != tx_rp_q[AW]) && (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0]);
  assign tx_pop   = (tx_st_q == S_IDLE) && !tx_empty;
  // The engine pop frees a slot on the same edge, so a write to a full FIFO still lands.
  assign tx_push  = write_nic && (!tx_full || tx_pop);
  assign tx_head  = tx_mem_q[tx_rp_q[AW-1:0]];
  assign tx_wp_d  = tx_wp_q + {{AW{1'b0}}, tx_push};
  assign tx_rp_d  = tx_rp_q + {{AW{1'b0}}, tx_pop};

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wp_q[AW-1:0]] <= send_data_to_nic;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wp_q <= '0;
      tx_rp_q <= '0;
    end else begin
      tx_wp_q <= tx_wp_d;
      tx_rp_q <= tx_rp_d;
    end
  end

  // ---------------- TX engine ----------------
  logic [CW-1:0] tx_cnt_q;
  logic [2:0]    tx_bit_q;
  logic [7:0]    tx_sh_q;
  logic          tx_q;
`ifdef UART_NIC_PARITY_EN
  logic          tx_par_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st_q  <= S_IDLE;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q  <= '0;
      tx_q     <= 1'b1;
`ifdef UART_NIC_PARITY_EN
      tx_par_q <= 1'b0;
`endif
    end else begin
      case (tx_st_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (tx_pop) begin
            tx_sh_q  <= tx_head;
            tx_q     <= 1'b0;
            tx_cnt_q <= '0;
            tx_st_q  <= S_START;
`ifdef UART_NIC_PARITY_EN
            tx_par_q <= ^tx_head;
`endif
          end
        end
        S_START: begin
          if (tx_cnt_q == BIT_END) begin
            tx_cnt_q <= '0;
            tx_bit_q <= '0;
            tx_q     <= tx_sh_q[0];
            tx_st_q  <= S_DATA;
          end else tx_cnt_q <= tx_cnt_q + 1'b1;
        end
        S_DATA: begin
          if (tx_cnt_q == BIT_END) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 3'd7) begin
`ifdef UART_NIC_PARITY_EN
              tx_q    <= tx_par_q;
              tx_st_q <= S_PAR;
`else
              tx_q    <= 1'b1;
              tx_st_q <= S_STOP;
`endif
            end else begin
              tx_bit_q <= tx_bit_q + 1'b1;
              tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
              tx_q     <= tx_sh_q[1];
            end
          end else tx_cnt_q <= tx_cnt_q + 1'b1;
        end
`ifdef UART_NIC_PARITY_EN
        S_PAR: begin
          if (tx_cnt_q == BIT_END) begin
            tx_cnt_q <= '0;
            tx_q     <= 1'b1;
            tx_st_q  <= S_STOP;
          end else tx_cnt_q <= tx_cnt_q + 1'b1;
        end
`endif
        S_STOP: begin
          if (tx_cnt_q == BIT_END) begin
            tx_cnt_q <= '0;
            tx_st_q  <= S_IDLE;
          end else tx_cnt_q <= tx_cnt_q + 1'b1;
        end
        default: tx_st_q <= S_IDLE;
      endcase
    end
  end

  assign tx = tx_q;

  // ---------------- RX synchronizer and engine ----------------
  logic          rx_s1_q, rx_s2_q, rx_s3_q, rx_fall;
  state_e        rx_st_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_sh_q;
  logic          rx_par_ok, rx_stop_hit, rx_good;
  logic          rx_overrun_q, frame_err_q;
`ifdef UART_NIC_PARITY_EN
  logic          rx_perr_q;
  assign rx_par_ok = ~rx_perr_q;
`else
  assign rx_par_ok = 1'b1;
`endif

  // RX FIFO signals used by the engine for overrun decisions
  logic [7:0]  rx_mem_q [FIFO_DEPTH];
  logic [AW:0] rx_wp_q, rx_rp_q, rx_wp_d, rx_rp_d;
  logic        rx_empty, rx_full, rx_pop, rx_push;
  logic [7:0]  rx_head_d, rec_q;
  logic        send_q;

  assign rx_fall     = rx_s3_q & ~rx_s2_q;
  assign rx_stop_hit = (rx_st_q == S_STOP) && (rx_cnt_q == BIT_END);
  assign rx_good     = rx_stop_hit && rx_s2_q && rx_par_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_s3_q      <= 1'b1;
      rx_st_q      <= S_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_sh_q      <= '0;
      rx_overrun_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_NIC_PARITY_EN
      rx_perr_q    <= 1'b0;
`endif
    end else begin
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
      if (rx_good && rx_full && !rx_pop) rx_overrun_q <= 1'b1;
      if (rx_stop_hit && !(rx_s2_q && rx_par_ok)) frame_err_q <= 1'b1;
      case (rx_st_q)
        S_IDLE: begin
          if (rx_fall) begin
            rx_cnt_q <= '0;
            rx_st_q  <= S_START;
          end
        end
        S_START: begin
          if (rx_cnt_q == HALF_END) begin
            rx_cnt_q <= '0;
            rx_bit_q <= '0;
            rx_st_q  <= rx_s2_q ? S_IDLE : S_DATA;
          end else rx_cnt_q <= rx_cnt_q + 1'b1;
        end
        S_DATA: begin
          if (rx_cnt_q == BIT_END) begin
            rx_cnt_q <= '0;
            rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
            rx_bit_q <= rx_bit_q + 1'b1;
`ifdef UART_NIC_PARITY_EN
            if (rx_bit_q == 3'd7) rx_st_q <= S_PAR;
`else
            if (rx_bit_q == 3'd7) rx_st_q <= S_STOP;
`endif
          end else rx_cnt_q <= rx_cnt_q + 1'b1;
        end
`ifdef UART_NIC_PARITY_EN
        S_PAR: begin
          if (rx_cnt_q == BIT_END) begin
            rx_cnt_q  <= '0;
            rx_perr_q <= rx_s2_q ^ (^rx_sh_q);
            rx_st_q   <= S_STOP;
          end else rx_cnt_q <= rx_cnt_q + 1'b1;
        end
`endif
        S_STOP: begin
          if (rx_cnt_q == BIT_END) begin
            rx_cnt_q <= '0;
            rx_st_q  <= S_IDLE;
          end else rx_cnt_q <= rx_cnt_q + 1'b1;
        end
        default: rx_st_q <= S_IDLE;
      endcase
    end
  end

  // ---------------- RX FIFO ----------------
  assign rx_empty = (rx_wp_q == rx_rp_q);
  assign rx_full  = (rx_wp_q[AW] != rx_rp_q[AW]) && (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0]);
  assign rx_pop   = read_nic && !rx_empty;
  assign rx_push  = rx_good && (!rx_full || rx_pop);
  assign rx_wp_d  = rx_wp_q + {{AW{1'b0}}, rx_push};
  assign rx_rp_d  = rx_rp_q + {{AW{1'b0}}, rx_pop};
  // A push into a FIFO that is empty after this edge becomes the new head directly.
  assign rx_head_d = (rx_push && (rx_wp_q == rx_rp_d)) ? rx_sh_q : rx_mem_q[rx_rp_d[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wp_q[AW-1:0]] <= rx_sh_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wp_q <= '0;
      rx_rp_q <= '0;
      send_q  <= 1'b0;
      rec_q   <= '0;
    end else begin
      rx_wp_q <= rx_wp_d;
      rx_rp_q <= rx_rp_d;
      send_q  <= (rx_wp_d != rx_rp_d);
      if (rx_wp_d != rx_rp_d) rec_q <= rx_head_d;
    end
  end

  assign rec_data_from_nic = rec_q;
  assign send_data_o       = send_q;
  assign rx_overrun        = rx_overrun_q;
  assign frame_err         = frame_err_q;

endmodule
